// File: rtl/mux_2to1.sv
// 2:1 word multiplexer for the Sobel gradient path: combinational result plus
// a registered copy with load enable and synchronous active-high reset.
module mux_2to1 #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  // Conditional operator merges bitwise on an unknown sel, so equal inputs
  // still produce a clean value in simulation.
  always_comb begin
    y = sel ? in1 : in0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= RESET_VALUE;
    end else if (en) begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1: default, non-zero reset value
// and 13-bit instances.
module tb_mux_2to1;

  logic        clk;
  logic        reset;
  logic [7:0]  in0, in1;
  logic        sel, en;
  logic [7:0]  y_a, y_q_a, y_b, y_q_b;

  logic [12:0] w_in0, w_in1;
  logic        w_sel, w_en;
  logic [12:0] y_c, y_q_c;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mux_2to1 u_a (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1),
    .sel(sel), .en(en), .y(y_a), .y_q(y_q_a)
  );

  mux_2to1 #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_b (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1),
    .sel(sel), .en(en), .y(y_b), .y_q(y_q_b)
  );

  mux_2to1 #(.WIDTH(13), .RESET_VALUE(13'h0000)) u_c (
    .clk(clk), .reset(reset), .in0(w_in0), .in1(w_in1),
    .sel(w_sel), .en(w_en), .y(y_c), .y_q(y_q_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_y, prev_y;
    logic [8:0] v;

    reset = 1'b1; en = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;
    w_in0 = '0; w_in1 = '0; w_sel = 1'b0; w_en = 1'b0;
    tick();
    tick();
    check("rst_a", y_q_a, 8'h00);
    check("rst_b", y_q_b, 8'hA5);
    check("rst_c", y_q_c, 13'h0000);

    // combinational select, valid during reset
    in0 = 8'h3C; in1 = 8'hC4; sel = 1'b0; #1;
    check("comb_sel0", y_a, 8'h3C);
    sel = 1'b1; #1;
    check("comb_sel1", y_a, 8'hC4);

    // identical inputs
    in0 = 8'h5A; in1 = 8'h5A;
    sel = 1'b0; #1; check("same_s0", y_a, 8'h5A);
    sel = 1'b1; #1; check("same_s1", y_a, 8'h5A);
    sel = 1'b0; #1; check("same_s0b", y_a, 8'h5A);
    sel = 1'bx; #1; check("same_sx", y_a, 8'h5A);
    sel = 1'b0;

    // reset priority over a simultaneous load
    reset = 1'b0; en = 1'b1; in0 = 8'hFF; sel = 1'b0;
    tick();
    check("load_ff_a", y_q_a, 8'hFF);
    check("load_ff_b", y_q_b, 8'hFF);
    reset = 1'b1; en = 1'b1; sel = 1'b1; in1 = 8'h11;
    tick();
    check("rstprio_a", y_q_a, 8'h00);
    check("rstprio_b", y_q_b, 8'hA5);

    // first edge after reset with en=1 loads, then hold with en=0
    reset = 1'b0; en = 1'b1; sel = 1'b0; in0 = 8'h1B;
    tick();
    check("en_load", y_q_a, 8'h1B);
    en = 1'b0; in0 = 8'h77;
    for (int i = 0; i < 3; i++) begin
      sel = i[0]; #1;
      check("hold_y", y_a, (i[0] ? 8'h11 : 8'h77));
      tick();
      check("hold_yq", y_q_a, 8'h1B);
      check("hold_yq_b", y_q_b, 8'h1B);
    end

    // exhaustive sweep with en held
    en = 1'b1;
    sel = 1'b0; in0 = 8'h00; in1 = 8'hFF;
    tick();
    prev_y = 8'h00;
    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      sel = v[8]; in0 = v[7:0]; in1 = ~v[7:0];
      exp_y = v[8] ? ~v[7:0] : v[7:0];
      #1;
      check("sweep_y", y_a, exp_y);
      check("sweep_yq_pre", y_q_a, prev_y);
      tick();
      check("sweep_yq", y_q_a, exp_y);
      prev_y = exp_y;
    end

    // 13-bit instance, full width preserved
    w_en = 1'b1; w_in0 = 13'h1FFF; w_in1 = 13'h0001;
    w_sel = 1'b0; #1;
    check("w13_y0", y_c, 13'h1FFF);
    tick();
    check("w13_yq0", y_q_c, 13'h1FFF);
    w_sel = 1'b1; #1;
    check("w13_y1", y_c, 13'h0001);
    tick();
    check("w13_yq1", y_q_c, 13'h0001);
    w_sel = 1'b0;
    tick();
    check("w13_yq2", y_q_c, 13'h1FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterised 2:1 word multiplexer used in the Sobel edge-detection datapath.
- Selects between a raw gradient difference and its corrected form, driven by the subtractor borrow bit.
- Provides a combinational output for same-cycle datapath use, plus a registered copy with clock enable for pipelined use.
- One clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 8, data width of both inputs and both outputs (must be >= 1).
- RESET_VALUE, 0, value loaded into the registered output on reset; WIDTH bits, zero-extended or truncated to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; acts only on the rising edge of clk.
- in0  input  WIDTH  data input selected when sel=0.
- in1  input  WIDTH  data input selected when sel=1.
- sel  input  1  select; 0 picks in0, 1 picks in1.
- en  input  1  load enable for the registered output.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  registered mux result.

Behaviour:
- Combinational output y:
  - y = in0 when sel=0; y = in1 when sel=1.
  - Purely combinational, zero latency; it must follow input changes within the same cycle.
  - No dependence on clk, reset or en; y is valid during reset.
- X/Z on sel:
  - If in0 == in1, y equals that value.
  - Otherwise y is X in simulation; no synthesis-time special handling.
- Registered output y_q, evaluated on every rising edge of clk, in priority order:
  1. reset=1: y_q <= RESET_VALUE, regardless of en, sel or data.
  2. else en=1: y_q <= current value of y (the sel-selected input sampled at the edge).
  3. else: y_q holds its previous value.
- Latency: in0/in1/sel to y is 0 cycles; to y_q is 1 cycle (visible after the edge where en=1).
- Reset mid-operation: a reset asserted on any edge overrides a simultaneous en=1 load. On the first edge after reset deasserts with en=1, the current y is loaded.
- Before the first reset edge, y_q is undefined; the bench must not check it until after reset.
- Width rules:
  - No arithmetic, no sign interpretation; all WIDTH bits pass unchanged.
  - The MSB is treated like any other bit (carries sign/borrow-related data in the Sobel path).
- No handshake; en is a level-sampled load qualifier.
- Both outputs are driven at all times; no tristate.

Test Plan:
- Combinational select: WIDTH=8, in0=8'h3C, in1=8'hC4; sel=0 -> y=8'h3C; sel=1 -> y=8'hC4, same delta cycle, no clock edge needed.
- Identical inputs: in0=in1=8'h5A, toggle sel 0/1/0 -> y stays 8'h5A throughout. Drive sel=1'bx -> y=8'h5A.
- Reset priority: y_q holding 8'hFF, then on one edge drive reset=1, en=1, sel=1, in1=8'h11 -> after the edge y_q=8'h00 (RESET_VALUE). Repeat with RESET_VALUE=8'hA5 -> y_q=8'hA5.
- Enable/hold: after reset, drive en=1, sel=0, in0=8'h1B and clock -> y_q=8'h1B. Then en=0, in0=8'h77, sel toggled, clock 3 times -> y_q stays 8'h1B while y tracks the inputs.
- Latency and exhaustive sweep: with en=1 held, apply all 512 combinations of sel and in0 (in1=~in0) on consecutive cycles -> y matches the reference mux immediately, and y_q equals the previous cycle's y on every edge.
- Width parameter: WIDTH=13, in0=13'h1FFF, in1=13'h0001, sel toggled with en=1 -> y and y_q carry the full 13 bits with no truncation.
